// File: rtl/div_seq_pkg.sv
// Shared types and constants for the divider request sequencer.
package div_seq_pkg;

  localparam int DIV_SEQ_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ARM,
    WAIT
  } div_seq_state_t;

  typedef struct packed {
    logic [DIV_SEQ_WIDTH-1:0] dividend;
    logic [DIV_SEQ_WIDTH-1:0] divisor;
  } div_seq_req_t;

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO for the divider sequencer: {dividend, divisor} entries,
// show-ahead head output so the sequencer can act on the entry it pops.
module div_req_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [2*WIDTH-1:0]       din_i,
  input  logic                     pop_i,
  output logic [2*WIDTH-1:0]       dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               push_ok, pop_ok;

  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign push_ok = push_i && (count_q != FULL_CNT);
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/div_request_sequencer.sv
// Buffers division requests and issues them to a start/done divider one at a time.
// Optional DIV_SEQ_DBZ_BYPASS_EN: zero-divisor requests are answered locally.
module div_request_sequencer
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_SEQ_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_quotient,
  output logic [WIDTH-1:0] res_remainder,
  output logic             res_dbz,
  output logic             busy
);

  div_seq_state_t state_q, state_d;

  logic [2*WIDTH-1:0]     fifo_dout;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [WIDTH-1:0]       head_dividend, head_divisor;
  logic                   pop, bypass, capture;

  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_quo_q, res_quo_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;

  div_req_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid),
    .din_i   ({req_dividend, req_divisor}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_dividend = fifo_dout[2*WIDTH-1:WIDTH];
  assign head_divisor  = fifo_dout[WIDTH-1:0];

  // Popping only with an empty result register guarantees a result is never overwritten.
  assign pop     = (state_q == IDLE) && !fifo_empty && !res_valid_q;
  assign capture = (state_q == WAIT) && div_done;

`ifdef DIV_SEQ_DBZ_BYPASS_EN
  assign bypass = pop && (head_divisor == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop && !bypass) state_d = ISSUE;
      ISSUE:   state_d = ARM;
      // A done left high by the previous operation must drop before we trust it.
      ARM:     if (!div_done) state_d = WAIT;
      WAIT:    if (div_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    res_valid_d = res_valid_q;
    res_quo_d   = res_quo_q;
    res_rem_d   = res_rem_q;
    if (pop) begin
      dividend_d = head_dividend;
      divisor_d  = head_divisor;
    end
    if (capture) begin
      res_valid_d = 1'b1;
      res_quo_d   = div_quotient;
      res_rem_d   = div_remainder;
    end else if (bypass) begin
      res_valid_d = 1'b1;
      res_quo_d   = '1;
      res_rem_d   = head_dividend;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      res_valid_q <= 1'b0;
      res_quo_q   <= '0;
      res_rem_q   <= '0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      res_valid_q <= res_valid_d;
      res_quo_q   <= res_quo_d;
      res_rem_q   <= res_rem_d;
    end
  end

`ifdef DIV_SEQ_DBZ_BYPASS_EN
  logic res_dbz_q, res_dbz_d;

  always_comb begin
    res_dbz_d = res_dbz_q;
    if (capture)     res_dbz_d = 1'b0;
    else if (bypass) res_dbz_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_dbz_q <= 1'b0;
    else     res_dbz_q <= res_dbz_d;
  end

  assign res_dbz = res_dbz_q;
`else
  assign res_dbz = 1'b0;
`endif

  assign req_ready     = !fifo_full;
  assign div_start     = (state_q == ISSUE);
  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;
  assign res_valid     = res_valid_q;
  assign res_quotient  = res_quo_q;
  assign res_remainder = res_rem_q;
  assign busy          = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_div_request_sequencer.sv
// Randomized bench for div_request_sequencer with a behavioural divider and
// an in-order result scoreboard; honours DIV_SEQ_DBZ_BYPASS_EN.
module tb_div_request_sequencer;
  import div_seq_pkg::*;

  localparam int W = 4;
  localparam int D = 4;
`ifdef DIV_SEQ_DBZ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_dividend = '0;
  logic [W-1:0] req_divisor = '0;
  logic         div_start;
  logic [W-1:0] div_dividend, div_divisor;
  logic         div_done = 1'b0;
  logic [W-1:0] div_quotient = '0;
  logic [W-1:0] div_remainder = '0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_quotient, res_remainder;
  logic         res_dbz;
  logic         busy;

  always #5 clk = ~clk;

  div_request_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_quotient  (res_quotient),
    .res_remainder (res_remainder),
    .res_dbz       (res_dbz),
    .busy          (busy)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected {dbz, quotient, remainder} straight from the arithmetic rules.
  function automatic logic [2*W:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {BYP, {W{1'b1}}, a};
    return {1'b0, W'(a / b), W'(a % b)};
  endfunction

  div_seq_req_t exp_q[$];
  div_seq_req_t issue_q[$];

  // Scoreboard: record accepted requests, retire results in order, watch hold stability.
  bit           hold_prev = 1'b0;
  logic [W-1:0] prev_quo, prev_rem;
  logic         prev_dbz;

  always @(negedge clk) begin
    div_seq_req_t e;
    logic [2*W:0] m;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", res_valid, 1);
        check("hold_quotient", res_quotient, prev_quo);
        check("hold_remainder", res_remainder, prev_rem);
        check("hold_dbz", res_dbz, prev_dbz);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          m = model_res(e.dividend, e.divisor);
          $display("result %0d/%0d -> q=%0d r=%0d dbz=%0d", e.dividend, e.divisor,
                   res_quotient, res_remainder, res_dbz);
          check("res_quotient", res_quotient, m[2*W-1:W]);
          check("res_remainder", res_remainder, m[W-1:0]);
          check("res_dbz", res_dbz, m[2*W]);
        end
      end
      if (req_valid && req_ready) begin
        e.dividend = req_dividend;
        e.divisor  = req_divisor;
        exp_q.push_back(e);
        if (!(BYP && req_divisor == '0)) issue_q.push_back(e);
      end
      hold_prev = res_valid && !res_ready;
      prev_quo  = res_quotient;
      prev_rem  = res_remainder;
      prev_dbz  = res_dbz;
    end
  end

  // Behavioural divider: done lingers for a few cycles after start, then a latency.
  int           starts = 0;
  int           phase = 0;
  int           stale_cnt = 0;
  int           lat_cnt = 0;
  int           stale_cfg = -1;
  int           lat_cfg = 0;
  bit           op_chk = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;

  always @(negedge clk) begin
    div_seq_req_t e;
    if (rst) op_chk = 1'b0;
    if (div_start) begin
      starts++;
      if (issue_q.size() == 0) begin
        check("start_unexpected", 1, 0);
      end else begin
        e = issue_q.pop_front();
        check("op_dividend", div_dividend, e.dividend);
        check("op_divisor", div_divisor, e.divisor);
      end
      op_a      = div_dividend;
      op_b      = div_divisor;
      stale_cnt = (stale_cfg >= 0) ? stale_cfg : int'($urandom_range(0, 3));
      lat_cnt   = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 6));
      phase     = 1;
      op_chk    = 1'b1;
    end else if (phase == 1) begin
      if (stale_cnt > 0) stale_cnt--;
      else begin
        div_done = 1'b0;
        phase    = 2;
      end
    end else if (phase == 2) begin
      if (lat_cnt > 1) lat_cnt--;
      else begin
        div_done      = 1'b1;
        div_quotient  = (op_b == '0) ? {W{1'b1}} : W'(op_a / op_b);
        div_remainder = (op_b == '0) ? op_a : W'(op_a % op_b);
        phase         = 0;
        if (op_chk) begin
          check("op_stable_dividend", div_dividend, op_a);
          check("op_stable_divisor", div_divisor, op_b);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc = 1'b0;
    req_valid    = 1'b1;
    req_dividend = a;
    req_divisor  = b;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    check("send_accepted", acc, 1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done_ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !res_valid) begin
        done_ok = 1'b1;
        break;
      end
    end
    check("drain", done_ok, 1);
    check("issue_q_empty", issue_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, div_start, 0);
    check({tag, "_dividend"}, div_dividend, 0);
    check({tag, "_divisor"}, div_divisor, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_quotient"}, res_quotient, 0);
    check({tag, "_res_remainder"}, res_remainder, 0);
    check({tag, "_res_dbz"}, res_dbz, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  bit rand_on = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  s0;
    bit  seen;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_req_ready", req_ready, 1);

    // Single request, start pulse one cycle after the pop.
    send(4'd13, 4'd3);
    @(posedge clk);
    @(negedge clk);
    check("single_start", div_start, 1);
    drain();

    // Burst.
    send(4'd15, 4'd4);
    send(4'd9, 4'd9);
    send(4'd7, 4'd2);
    send(4'd0, 4'd5);
    drain();

    // Backpressure: pending result blocks pops, FIFO fills and refuses more.
    res_ready = 1'b0;
    send(4'd1, 4'd1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_first_result", seen, 1);
    @(posedge clk);
    #1;
    s0 = starts;
    for (int i = 0; i < D; i++) send(W'(i + 5), W'(i + 2));
    req_valid    = 1'b1;
    req_dividend = 4'd3;
    req_divisor  = 4'd3;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_full_req_ready", req_ready, 0);
    check("bp_busy", busy, 1);
    check("bp_no_start", starts - s0, 0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    drain();

    // Stale done: previous done held high well into ARM.
    stale_cfg = 3;
    lat_cfg   = 2;
    send(4'd14, 4'd3);
    send(4'd5, 4'd2);
    drain();
    stale_cfg = -1;
    lat_cfg   = 0;

    // Divide by zero.
    send(4'd9, 4'd0);
    @(posedge clk);
    @(negedge clk);
`ifdef DIV_SEQ_DBZ_BYPASS_EN
    check("dbz_valid", res_valid, 1);
    check("dbz_quotient", res_quotient, 15);
    check("dbz_remainder", res_remainder, 9);
    check("dbz_flag", res_dbz, 1);
`else
    check("dbz_start", div_start, 1);
`endif
    drain();

    // Reset while waiting on the divider with more requests queued.
    stale_cfg = 0;
    lat_cfg   = 10;
    send(4'd11, 4'd2);
    send(4'd6, 4'd3);
    send(4'd8, 4'd1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (phase == 2 && lat_cnt <= 8) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_reached_wait", seen, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    issue_q.delete();
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_req_ready", req_ready, 1);
    check("midrst_busy", busy, 0);
    s0   = starts;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("midrst_no_result", seen, 0);
    check("midrst_no_start", starts - s0, 0);
    stale_cfg = -1;
    lat_cfg   = 0;
    @(posedge clk);
    #1;

    // Random traffic with random downstream backpressure.
    rand_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          send(W'($urandom_range(0, 15)),
               ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 15)));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          res_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    res_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
